mux_out_skid_64: RTL and testbench

Registered output stage placed directly downstream of the 64-bit 2:1 mux datapath. It captures the mux result under a valid/ready handshake and presents it to the next stage from registers. A two-entry skid buffer keeps full throughput under backpressure without a combinational ready path. A wrapping transfer counter supports debug and bench checking.

---
 rtl/mux_out_skid_64.sv | 141 ++++++++++++++
 tb/tb_mux_out_skid_64.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_out_skid_64.sv
`default_nettype none
// ============================================================================
// Module   : mux_out_skid_64
// Brief    : Registered output stage placed after the 64-bit 2:1 mux. It
//            accepts words under a valid/ready handshake and delivers them
//            from a main register, with a skid register behind it so that
//            downstream stalls do not need a combinational ready path.
//            A wrapping counter tracks how many words have been delivered.
// Revision : 1.0 - initial release
// ============================================================================
module mux_out_skid_64 #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_cnt
);

    // 2'b01 is deliberately left unused; landing there recovers to EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_TWO   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_xfer_cnt;

    logic             w_accept;
    logic             w_deliver;
    logic             w_main_from_in;
    logic             w_main_from_skid;
    logic             w_skid_load;
    logic             w_in_ready_nxt;
    logic             w_out_valid_nxt;

    // Handshake qualifiers; both ready/valid come straight from flops.
    assign w_accept  = in_valid & r_in_ready;
    assign w_deliver = r_out_valid & out_ready;

    // Next-state decode and data-steering selects for the two storage slots.
    always_comb begin
        w_state_nxt      = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_main_from_in = 1'b1;
                    w_state_nxt    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_deliver) begin
                    w_main_from_in = 1'b1;
                end else if (w_accept) begin
                    w_skid_load = 1'b1;
                    w_state_nxt = ST_TWO;
                end else if (w_deliver) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_deliver) begin
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Ready/valid flags are precomputed from the next state so they leave flops.
    always_comb begin
        w_in_ready_nxt  = (w_state_nxt != ST_TWO);
        w_out_valid_nxt = (w_state_nxt != ST_EMPTY);
    end

    // Control state and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Main and skid data registers; in_data is only sampled on an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_main_from_in) begin
                r_main <= in_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_load) begin
                r_skid <= in_data;
            end
        end
    end

    // Delivered-word counter, wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (w_deliver) begin
            r_xfer_cnt <= r_xfer_cnt + c_cnt_one;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign xfer_cnt  = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux_out_skid_64.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_out_skid_64
// Brief    : Self-checking bench for mux_out_skid_64. A reference FIFO of
//            depth two (queue) predicts every output each cycle. A second
//            instance with a 4-bit counter exercises counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_out_skid_64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready, in_ready_w;
    logic [63:0] out_data, out_data_w;
    logic        out_valid, out_valid_w;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;

    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model: words held by the stage, oldest first, and words out.
    logic [63:0] mq[$];
    int          m_cnt = 0;

    always #5 clk = ~clk;

    mux_out_skid_64 u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (cnt16)
    );

    mux_out_skid_64 #(.WIDTH(64), .CNT_W(4)) u_dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w),
        .out_data  (out_data_w),
        .out_valid (out_valid_w),
        .out_ready (out_ready),
        .xfer_cnt  (cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Check outputs at the falling edge, then advance the model across the
    // rising edge. Called with inputs already driven.
    task automatic cycle_check();
        bit          do_del;
        bit          do_acc;
        logic [63:0] d;
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        chk("out_valid_w", 64'(out_valid_w), 64'(mq.size() != 0));
        chk("in_ready_w", 64'(in_ready_w), 64'(mq.size() < 2));
        if (mq.size() != 0) begin
            chk("out_data", out_data, mq[0]);
            chk("out_data_w", out_data_w, mq[0]);
        end
        chk("cnt16", 64'(cnt16), 64'(m_cnt % 65536));
        chk("cnt4", 64'(cnt4), 64'(m_cnt % 16));
        do_del = (mq.size() != 0) && out_ready;
        do_acc = in_valid && (mq.size() < 2);
        d      = in_data;
        @(posedge clk);
        if (do_del) begin
            void'(mq.pop_front());
            m_cnt++;
        end
        if (do_acc) mq.push_back(d);
        #1;
    endtask

    // Assert reset asynchronously, hold it over two edges, release after an edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_cnt", 64'(cnt16), 64'd0);
        mq.delete();
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_valid", 64'(out_valid), 64'd0);
        chk("rst_hold_data", out_data, 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'hFFFF_FFFF_FFFF_FFFF;
        out_ready = 1'b1;
        #1;

        // Reset with valid all-ones input pending, then first word after release.
        do_reset();
        cycle_check();
        chk("first_word", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        in_valid = 1'b0;
        cycle_check();

        // Streaming 0..7 at full rate.
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 64'(i);
            cycle_check();
            chk("stream_lat", out_data, 64'(i));
        end
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        repeat (2) cycle_check();
        chk("stream_cnt", 64'(cnt16), 64'd8);

        // Backpressure into the skid register.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA5;
        cycle_check();
        in_data = 64'h5A;
        cycle_check();
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_hold", out_data, 64'hA5);
        in_data = 64'h77;
        repeat (2) cycle_check();
        chk("bp_hold2", out_data, 64'hA5);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        cycle_check();
        chk("bp_second", out_data, 64'h5A);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        cycle_check();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Counter wrap on the 4-bit instance: 17 words delivered.
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 19; k++) begin
            in_valid = (k < 17);
            in_data  = {$urandom, $urandom};
            cycle_check();
            if (m_cnt == 15) chk("wrap15", 64'(cnt4), 64'd15);
            if (m_cnt == 16) chk("wrap0", 64'(cnt4), 64'd0);
            if (m_cnt == 17) chk("wrap1", 64'(cnt4), 64'd1);
        end
        chk("wrap_total", 64'(m_cnt), 64'd17);

        // Mid-stream reset while both slots are full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (2) begin
            in_data = {$urandom, $urandom};
            cycle_check();
        end
        chk("mid_full", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid_drop", 64'(out_valid), 64'd0);
        chk("mid_ready", 64'(in_ready), 64'd1);
        mq.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_data   = 64'h1234;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle_check();
        chk("mid_next", out_data, 64'h1234);
        in_valid = 1'b0;
        repeat (2) cycle_check();
        chk("mid_cnt", 64'(cnt16), 64'd1);

        // Randomised bubbles and backpressure.
        for (int i = 0; i < 1000; i++) begin
            in_valid  = (i < 500) ? (i % 2 == 0) : 1'($urandom_range(0, 1));
            in_data   = {$urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
            cycle_check();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle_check();
        chk("drain_empty", 64'(mq.size()), 64'd0);
        chk("final_cnt", 64'(cnt16), 64'(m_cnt % 65536));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
